// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC ownership, imem handshake, next-PC select.
// Optional FETCH_TIMEOUT_EN adds a request watchdog that traps into a sticky FAULT state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic        jump,
  input  logic        pc_src,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  op_code,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_w;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  if (TIMEOUT < 1 || TIMEOUT > 255 || RESET_PC[1:0] != 2'b00) begin : g_bad_cfg
    $error("instr_fetch: TIMEOUT must be 1..255 and RESET_PC word aligned");
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    pc_plus4_w = pc_q + 32'd4;
    br_off     = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump)
      next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    else if (pc_src)
      next_pc = pc_plus4_w + br_off;
    else
      next_pc = pc_plus4_w;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
        wait_d  = 8'd0;
`endif
      end
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        // Counter holds the number of ack-less cycles already spent in REQ.
        else if (wait_q == 8'(TIMEOUT - 1)) begin
          state_d = FAULT;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
      HOLD: begin
        if (advance) begin
          pc_d    = next_pc;
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = 8'd0;
`endif
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign op_code     = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle MIPS core. It sits directly upstream of the control unit and datapath, and owns the program counter. It fetches each 32-bit instruction from instruction memory over a request/acknowledge handshake, then holds it stable while the datapath executes it. It splits out `op_code`/`funct` for the control unit and computes the next PC from the control unit's `jump` and `pc_src` outputs.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- `TIMEOUT`, 255, max cycles a memory request may wait for `imem_ack` (used only with `FETCH_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of the requested word; equals `pc`.
- `imem_ack`  in  1  memory response valid; `imem_rdata` is sampled on this edge.
- `imem_rdata`  in  32  instruction word.
- `advance`  in  1  datapath has committed the current instruction.
- `jump`  in  1  from control unit.
- `pc_src`  in  1  from control unit (branch & zero).
- `instr`  out  32  current instruction register.
- `instr_valid`  out  1  `instr` holds a fetched, unexecuted instruction.
- `op_code`  out  6  `instr[31:26]`.
- `funct`  out  6  `instr[5:0]`.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, for the datapath (link/branch base).
- `fetch_err`  out  1  sticky memory-timeout flag (0 when the feature is absent).

## Operation
FSM with states IDLE, REQ, HOLD, FAULT:
- IDLE: entered only from reset. Moves to REQ on the next clock.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`, `instr` <= `imem_rdata` and the FSM moves to HOLD. `pc` never changes in REQ.
- HOLD: `instr_valid`=1. On `advance`, `pc` <= `next_pc` and the FSM moves to REQ. `advance` outside HOLD is ignored.
- FAULT: only with `FETCH_TIMEOUT_EN`. Terminal until `rst`. `imem_req`=0, `instr_valid`=0.

Next-PC selection (32-bit, wraps modulo 2^32, no overflow detection):
- If `jump`: next PC is {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}. `jump` has priority over `pc_src`.
- Else if `pc_src`: next PC is `pc_plus4` + (sign-extended `instr[15:0]` << 2).
- Otherwise: next PC is `pc_plus4`.

Other rules:
- `imem_ack` outside REQ is ignored.
- `instr`, `op_code` and `funct` are driven from the register, so they are stable for the whole of HOLD.

## Timing
- Reset values: `pc`=`RESET_PC`, `instr`=0 (nop), `instr_valid`=0, `imem_req`=0, `fetch_err`=0, state IDLE.
- First `imem_req` is asserted in the second cycle after `rst` deasserts.
- `imem_ack` may arrive in the same cycle `imem_req` rises (zero-latency memory) or any later cycle. `imem_addr` is held constant until ack.
- Ack at edge N gives `instr_valid`=1 after edge N.
- `advance` at edge M gives `imem_req`=1 with the new `pc` after edge M.
- Best-case throughput: one instruction per 2 cycles.
- `rst` asserted mid-request abandons the request immediately (async); a late ack after reset is ignored.
- `rst` wins over simultaneous `advance` or `imem_ack`.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT`, the FSM moves to FAULT and `fetch_err` is set and stays set until `rst`.
- Undefined: no counter and no FAULT state; REQ waits indefinitely; `fetch_err` is tied to 0.

## Test plan
- Reset with `RESET_PC`=0x100: `pc`=0x100, `instr_valid`=0, `imem_req`=0. Two cycles after release, `imem_req`=1 and `imem_addr`=0x100.
- Sequential fetch with 0-cycle and 3-cycle ack latency: addresses 0x100, 0x104, 0x108 in order. `instr` matches `imem_rdata`. `op_code` and `funct` equal their bit slices.
- Branch taken: `pc`=0x200, `instr[15:0]`=0xFFFE, `pc_src`=1, `advance` → next `imem_addr`=0x1FC.
- Jump with `pc_src` also 1: `pc`=0x3000_0000, `instr[25:0]`=0x0000040 → next `imem_addr`=0x3000_0100.
- Hold: `advance` held low for 10 cycles in HOLD → `instr` and `pc` unchanged, `imem_req`=0. A spurious `imem_ack` in HOLD does not change `instr`.
- Reset mid-REQ with a late ack: all outputs return to their reset values and fetch restarts at `RESET_PC`. With `FETCH_TIMEOUT_EN`, withholding ack for 255 cycles sets `fetch_err`=1 and `imem_req`=0.
